ddr_axi_wr_burst: RTL and testbench

- Downstream stage of the UART receive path. Consumes 256-bit packed words from the synchronous store FIFO and writes them to DDR as AXI4 INCR write bursts of (alen+1) beats.
- Reads the FIFO only when a full burst is resident. Issues AW, streams W with wlast, then waits for B.
- Advances a circular write pointer over a fixed DDR region.

---
 rtl/ddr_axi_wr_burst.sv | 169 ++++++++++++++++
 tb/tb_ddr_axi_wr_burst.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_wr_burst.sv
// Drains the store FIFO into DDR as AXI4 INCR write bursts of (alen+1) 32-byte beats,
// advancing a circular write pointer over a fixed power-of-two region.
module ddr_axi_wr_burst #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] REGION_BYTES = 32'h0010_0000
) (
    input  logic                axi_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          alen,
    input  logic [9:0]          occupants,
    output logic                fifo_rd_en,
    input  logic [DATA_W-1:0]   fifo_rdata,
    input  logic                fifo_rvalid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                burst_done,
    output logic                resp_err,
    output logic                cfg_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state_reg, state_next;
    logic [7:0]          len_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [ADDR_W-1:0]   awaddr_reg;
    logic [7:0]          awlen_reg;
    logic [8:0]          req_cnt_reg;
    logic [7:0]          beat_cnt_reg;
    logic                inflight_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                skid_valid_reg;
    logic [DATA_W-1:0]   skid_data_reg;
    logic                resp_err_reg;
    logic                bad_prev_reg;

    logic                alen_legal;
    logic                occ_ok;
    logic                start_cond;
    logic                start_ok;
    logic                bad_cond;
    logic [8:0]          beats_total;
    logic                w_fire;
    logic                incoming;
    logic [1:0]          held_words;
    logic                wlast_int;
    logic                b_fire;
    logic [ADDR_W-1:0]   ptr_adv;

    // alen+1 must be a power of two no larger than 128
    assign alen_legal  = !alen[7] && ((alen & (alen + 8'd1)) == 8'd0);
    assign occ_ok      = occupants >= ({2'b00, alen} + 10'd1);
    assign start_cond  = (state_reg == IDLE) && enable && occ_ok;
    assign start_ok    = start_cond && alen_legal;
    assign bad_cond    = start_cond && !alen_legal;
    assign beats_total = {1'b0, len_reg} + 9'd1;

    assign w_fire      = out_valid_reg && wready;
    assign incoming    = fifo_rvalid && inflight_reg;
    assign wlast_int   = out_valid_reg && (beat_cnt_reg == len_reg);
    assign b_fire      = (state_reg == RESP) && bvalid;

    // Occupancy after this cycle's beat leaves, so a pop can overlap a send
    assign held_words  = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(inflight_reg) - 2'(w_fire);
    assign fifo_rd_en  = (state_reg == DATA) && (req_cnt_reg < beats_total) && (held_words < 2'd2);

    assign ptr_adv     = (ptr_reg + (ADDR_W'(beats_total) << 5)) & (REGION_BYTES - 1'b1);

    assign awaddr      = awaddr_reg;
    assign awlen       = awlen_reg;
    assign awsize      = 3'b101;
    assign awburst     = 2'b01;
    assign awvalid     = (state_reg == ADDR);
    assign wdata       = out_data_reg;
    assign wstrb       = '1;
    assign wvalid      = out_valid_reg;
    assign wlast       = wlast_int;
    assign bready      = (state_reg == RESP);
    assign burst_done  = b_fire;
    assign resp_err    = resp_err_reg;
    assign cfg_err     = bad_cond && !bad_prev_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok)            state_next = ADDR;
            ADDR:    if (awready)             state_next = DATA;
            DATA:    if (w_fire && wlast_int) state_next = RESP;
            RESP:    if (bvalid)              state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            ptr_reg        <= '0;
            awaddr_reg     <= '0;
            awlen_reg      <= '0;
            req_cnt_reg    <= '0;
            beat_cnt_reg   <= '0;
            inflight_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            bad_prev_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bad_prev_reg <= bad_cond;
            inflight_reg <= fifo_rd_en;

            if (start_ok) begin
                len_reg      <= alen;
                awaddr_reg   <= BASE_ADDR + ptr_reg;
                awlen_reg    <= alen;
                req_cnt_reg  <= '0;
                beat_cnt_reg <= '0;
            end
            if (fifo_rd_en)
                req_cnt_reg <= req_cnt_reg + 9'd1;
            if (w_fire)
                beat_cnt_reg <= beat_cnt_reg + 8'd1;

            if (b_fire) begin
                ptr_reg <= ptr_adv;
                if (bresp != 2'b00)
                    resp_err_reg <= 1'b1;
            end

            // Output register refills from skid first to keep FIFO order
            if (w_fire || !out_valid_reg) begin
                if (skid_valid_reg) begin
                    out_valid_reg  <= 1'b1;
                    out_data_reg   <= skid_data_reg;
                    skid_valid_reg <= incoming;
                    if (incoming)
                        skid_data_reg <= fifo_rdata;
                end else begin
                    out_valid_reg <= incoming;
                    if (incoming)
                        out_data_reg <= fifo_rdata;
                end
            end else if (incoming) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= fifo_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ddr_axi_wr_burst.sv
// Directed bench for ddr_axi_wr_burst: FIFO model with 1-cycle read latency,
// AXI slave driven from the main sequence, W-channel scoreboard at the negedge.
module tb_ddr_axi_wr_burst;

    logic         axi_clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [7:0]   alen;
    logic [9:0]   occupants;
    logic         fifo_rd_en;
    logic [255:0] fifo_rdata;
    logic         fifo_rvalid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic         burst_done;
    logic         resp_err;
    logic         cfg_err;

    ddr_axi_wr_burst #(
        .ADDR_W(32), .DATA_W(256), .BASE_ADDR(32'h0), .REGION_BYTES(32'h0000_1000)
    ) dut (
        .axi_clk(axi_clk), .rst(rst), .enable(enable), .alen(alen), .occupants(occupants),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_rvalid(fifo_rvalid),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
        .bvalid(bvalid), .bready(bready), .burst_done(burst_done),
        .resp_err(resp_err), .cfg_err(cfg_err)
    );

    always #5 axi_clk = ~axi_clk;

    int          tests = 0;
    int          fails = 0;
    int          fifo_idx = 0;
    int          w_exp = 0;
    int          w_beat = 0;
    int          w_total = 0;
    int          rd_cnt = 0;
    int          aw_cnt = 0;
    int          bd_cnt = 0;
    int          cfg_cnt = 0;
    int          exp_len = 0;
    logic [31:0] aw_addr_seen = '0;
    logic [7:0]  aw_len_seen = '0;
    logic        pop_pending = 1'b0;
    logic        bp_on = 1'b0;
    int          bp_i = 0;
    logic [7:0]  bp_pat = 8'b0101_1001;

    function automatic logic [255:0] word(input int i);
        logic [255:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = {8'hA5, i[15:0], k[7:0]};
        return w;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
        if (bp_on) begin
            wready = bp_pat[bp_i];
            bp_i   = (bp_i + 1) % 8;
        end
    endtask

    // FIFO: data returns exactly one cycle after the pop request
    always @(posedge axi_clk) begin
        #1;
        fifo_rvalid = pop_pending;
        if (pop_pending) begin
            fifo_rdata = word(fifo_idx);
            fifo_idx++;
        end
    end

    always @(negedge axi_clk) begin
        pop_pending = fifo_rd_en;
        if (fifo_rd_en) rd_cnt++;
        if (awvalid && awready) begin
            aw_cnt++;
            aw_addr_seen = awaddr;
            aw_len_seen  = awlen;
            w_beat       = 0;
            $display("[TB] AW addr=%08h len=%0d", awaddr, awlen);
        end
        if (wvalid && wready) begin
            check("wdata", wdata, word(w_exp));
            check("wlast", wlast, (w_beat == exp_len));
            w_exp++;
            w_beat++;
            w_total++;
        end
        if (burst_done) begin
            bd_cnt++;
            $display("[TB] B resp=%0d resp_err=%0d", bresp, resp_err);
        end
        if (cfg_err) begin
            cfg_cnt++;
            $display("[TB] cfg_err alen=%0d", alen);
        end
    end

    task automatic run_burst(input int a, input logic [31:0] exp_addr);
        int aw0, bd0, rd0, wt0;
        aw0 = aw_cnt; bd0 = bd_cnt; rd0 = rd_cnt; wt0 = w_total;
        exp_len   = a;
        alen      = 8'(a);
        occupants = 10'(a + 1);
        enable    = 1'b1;
        tick();
        @(negedge axi_clk);
        check("awvalid_next", awvalid, 1'b1);
        #1;
        for (int i = 0; i < 20 && aw_cnt == aw0; i++) tick();
        enable = 1'b0;
        check("aw_count", aw_cnt - aw0, 1);
        check("awaddr", aw_addr_seen, exp_addr);
        check("awlen", aw_len_seen, 8'(a));
        for (int i = 0; i < 2000 && bd_cnt == bd0; i++) tick();
        repeat (3) tick();
        check("burst_done", bd_cnt - bd0, 1);
        check("beats", w_total - wt0, a + 1);
        check("rd_pulses", rd_cnt - rd0, a + 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        w_exp = fifo_idx;
    endtask

    initial begin
        int aw0, rd0, c0, wt0;
        rst = 1'b0; enable = 1'b0; alen = '0; occupants = '0;
        fifo_rvalid = 1'b0; fifo_rdata = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        repeat (3) tick();
        @(negedge axi_clk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_done", burst_done, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("awsize", awsize, 3'b101);
        check("awburst", awburst, 2'b01);
        check("wstrb", wstrb, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();

        // single bursts, then the pointer advances by 4*32
        run_burst(3, 32'h0000_0000);
        run_burst(3, 32'h0000_0080);

        // under-occupancy hold
        aw0 = aw_cnt; rd0 = rd_cnt;
        alen = 8'd7; occupants = 10'd7; enable = 1'b1;
        repeat (8) tick();
        check("hold_no_aw", aw_cnt - aw0, 0);
        check("hold_no_rd", rd_cnt - rd0, 0);
        run_burst(7, 32'h0000_0100);

        // backpressure on W
        bp_on = 1'b1; bp_i = 0;
        run_burst(15, 32'h0000_0200);
        bp_on = 1'b0; wready = 1'b1;

        // illegal alen: one pulse per rising of the start condition
        aw0 = aw_cnt; c0 = cfg_cnt;
        alen = 8'd5; occupants = 10'd6; enable = 1'b1;
        repeat (6) tick();
        check("cfg_once", cfg_cnt - c0, 1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        check("cfg_rise", cfg_cnt - c0, 2);
        check("cfg_no_aw", aw_cnt - aw0, 0);

        // error response: sticky flag, pointer still advances
        bresp = 2'b10;
        run_burst(0, 32'h0000_0400);
        bresp = 2'b00;
        check("resp_err_set", resp_err, 1'b1);
        run_burst(0, 32'h0000_0420);
        check("resp_err_sticky", resp_err, 1'b1);

        // wrap over a 4 KB region
        do_reset();
        check("resp_err_clr", resp_err, 1'b0);
        run_burst(127, 32'h0000_0000);
        run_burst(127, 32'h0000_0000);
        run_burst(63, 32'h0000_0000);
        run_burst(63, 32'h0000_0800);
        run_burst(63, 32'h0000_0000);

        // reset after two beats of an 8-beat burst
        exp_len = 7; alen = 8'd7; occupants = 10'd8; enable = 1'b1;
        wt0 = w_total;
        for (int i = 0; i < 50 && (w_total - wt0) < 2; i++) tick();
        enable = 1'b0;
        check("mid_beats", w_total - wt0, 2);
        rst = 1'b0;
        tick();
        @(negedge axi_clk);
        check("mid_awvalid", awvalid, 1'b0);
        check("mid_wvalid", wvalid, 1'b0);
        check("mid_rd_en", fifo_rd_en, 1'b0);
        check("mid_bready", bready, 1'b0);
        check("mid_done", burst_done, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        w_exp = fifo_idx;
        run_burst(7, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
